i2c_slave: RTL and testbench

- Byte-level I2C target (responder), the other end of the bus from i2c_master.
- Oversamples SCL/SDA on the system clock and detects START, repeated START and STOP.
- Matches a 7-bit address and moves bytes to/from user logic through pulse handshakes.
- Drives the bus only through open-drain enables; the top level maps enable=1 to a pull-low on the i2c_io_* pads, z otherwise.

---
 rtl/i2c_slave.sv | 251 +++++++++++++++++++++++++
 tb/tb_i2c_slave.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave.sv
// i2c_slave: byte-level I2C target with filtered SCL/SDA, 7-bit address match and pulse handshakes.
// Define I2CS_STRETCH_EN to hold SCL low while the next read byte is not yet valid.
module i2c_slave #(
    parameter logic [6:0] SLAVE_ADDR = 7'h42,
    parameter int          FILTER_LEN = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_scl,
    input  logic       i_sda,
    output logic       o_sda_oe,
    output logic       o_scl_oe,
    output logic [7:0] o_rx_data,
    output logic       o_rx_valid,
    output logic       o_tx_req,
    input  logic [7:0] i_tx_data,
    input  logic       i_tx_valid,
    output logic       o_start,
    output logic       o_stop,
    output logic       o_rw,
    output logic       o_busy
);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP
    } state_t;

    localparam logic [2:0] FLT_MAX = 3'(FILTER_LEN - 1);

    logic       scl_p0, scl_p1, sda_p0, sda_p1;
    logic       scl_flt, sda_flt, scl_dly, sda_dly;
    logic [2:0] scl_cnt, sda_cnt;
    logic       scl_rise, scl_fall, sda_rise, sda_fall, start_det, stop_det;

    state_t     state, state_n;
    logic [2:0] bit_cnt, bit_cnt_n;
    logic [6:0] rx_sr, rx_sr_n, tx_sr, tx_sr_n;
    logic [7:0] rx_byte, rx_data_n;
    logic       sda_oe_n, stretch, stretch_n, rw_n, busy_n, ack_ph, ack_ph_n;
    logic       rx_valid_n, tx_req_n, start_n, stop_n, load_pt, tx_rdy;

`ifdef I2CS_STRETCH_EN
    assign tx_rdy   = i_tx_valid;
    assign o_scl_oe = stretch;
`else
    logic unused_tx_valid;
    assign unused_tx_valid = i_tx_valid;
    assign tx_rdy          = 1'b1;
    assign o_scl_oe        = 1'b0;
`endif

    // Stage p0/p1: two-flop synchronizer, then a run-length glitch filter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_p0  <= 1'b1;
            scl_p1  <= 1'b1;
            sda_p0  <= 1'b1;
            sda_p1  <= 1'b1;
            scl_flt <= 1'b1;
            sda_flt <= 1'b1;
            scl_dly <= 1'b1;
            sda_dly <= 1'b1;
            scl_cnt <= '0;
            sda_cnt <= '0;
        end else begin
            scl_p0  <= i_scl;
            scl_p1  <= scl_p0;
            sda_p0  <= i_sda;
            sda_p1  <= sda_p0;
            scl_dly <= scl_flt;
            sda_dly <= sda_flt;
            if (scl_p1 == scl_flt) begin
                scl_cnt <= '0;
            end else if (scl_cnt == FLT_MAX) begin
                scl_flt <= scl_p1;
                scl_cnt <= '0;
            end else begin
                scl_cnt <= scl_cnt + 3'd1;
            end
            if (sda_p1 == sda_flt) begin
                sda_cnt <= '0;
            end else if (sda_cnt == FLT_MAX) begin
                sda_flt <= sda_p1;
                sda_cnt <= '0;
            end else begin
                sda_cnt <= sda_cnt + 3'd1;
            end
        end
    end

    assign scl_rise  = scl_flt & ~scl_dly;
    assign scl_fall  = ~scl_flt & scl_dly;
    assign sda_rise  = sda_flt & ~sda_dly;
    assign sda_fall  = ~sda_flt & sda_dly;
    assign start_det = sda_fall & scl_flt;
    assign stop_det  = sda_rise & scl_flt;
    assign rx_byte   = {rx_sr, sda_flt};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n    = state;
        bit_cnt_n  = bit_cnt;
        rx_sr_n    = rx_sr;
        tx_sr_n    = tx_sr;
        rx_data_n  = o_rx_data;
        sda_oe_n   = o_sda_oe;
        stretch_n  = stretch;
        rw_n       = o_rw;
        busy_n     = o_busy;
        ack_ph_n   = ack_ph;
        rx_valid_n = 1'b0;
        tx_req_n   = 1'b0;
        start_n    = 1'b0;
        stop_n     = 1'b0;
        load_pt    = 1'b0;
        if (stop_det) begin
            state_n   = IDLE;
            bit_cnt_n = '0;
            sda_oe_n  = 1'b0;
            stretch_n = 1'b0;
            busy_n    = 1'b0;
            ack_ph_n  = 1'b0;
            stop_n    = 1'b1;
        end else if (start_det) begin
            state_n   = ADDR;
            bit_cnt_n = '0;
            sda_oe_n  = 1'b0;
            stretch_n = 1'b0;
            busy_n    = 1'b0;
            ack_ph_n  = 1'b0;
            start_n   = 1'b1;
        end else if (stretch) begin
            if (tx_rdy) begin
                stretch_n = 1'b0;
                load_pt   = 1'b1;
            end
        end else begin
            case (state)
                ADDR: if (scl_rise) begin
                    rx_sr_n   = rx_byte[6:0];
                    bit_cnt_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        if (rx_byte[7:1] == SLAVE_ADDR) begin
                            rw_n    = rx_byte[0];
                            busy_n  = 1'b1;
                            state_n = ADDR_ACK;
                        end else begin
                            state_n = WAIT_STOP;
                        end
                    end
                end
                // ACK window: first SCL fall grabs SDA, second fall ends the slot
                ADDR_ACK, WR_ACK: if (scl_fall) begin
                    if (!o_sda_oe) begin
                        sda_oe_n = 1'b1;
                    end else if (state == ADDR_ACK && o_rw) begin
                        load_pt = 1'b1;
                    end else begin
                        sda_oe_n  = 1'b0;
                        bit_cnt_n = '0;
                        state_n   = WR_DATA;
                    end
                end else if (scl_rise && state == ADDR_ACK && o_rw) begin
                    tx_req_n = 1'b1;
                end
                WR_DATA: if (scl_rise) begin
                    rx_sr_n   = rx_byte[6:0];
                    bit_cnt_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        rx_data_n  = rx_byte;
                        rx_valid_n = 1'b1;
                        state_n    = WR_ACK;
                    end
                end
                RD_DATA: if (scl_rise) begin
                    bit_cnt_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        ack_ph_n = 1'b0;
                        state_n  = RD_ACK;
                    end
                end else if (scl_fall) begin
                    sda_oe_n = ~tx_sr[6];
                    tx_sr_n  = {tx_sr[5:0], 1'b0};
                end
                RD_ACK: if (scl_fall) begin
                    if (!ack_ph) sda_oe_n = 1'b0;
                    else         load_pt  = 1'b1;
                end else if (scl_rise) begin
                    if (!sda_flt) begin
                        tx_req_n = 1'b1;
                        ack_ph_n = 1'b1;
                    end else begin
                        state_n = WAIT_STOP;
                    end
                end
                IDLE, WAIT_STOP: ;
                default: state_n = IDLE;
            endcase
        end
        if (load_pt) begin
            if (tx_rdy) begin
                tx_sr_n   = i_tx_data[6:0];
                sda_oe_n  = ~i_tx_data[7];
                bit_cnt_n = '0;
                ack_ph_n  = 1'b0;
                state_n   = RD_DATA;
            end else begin
                stretch_n = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt    <= '0;
            o_sda_oe   <= 1'b0;
            stretch    <= 1'b0;
            o_rx_data  <= '0;
            o_rx_valid <= 1'b0;
            o_tx_req   <= 1'b0;
            o_start    <= 1'b0;
            o_stop     <= 1'b0;
            o_rw       <= 1'b0;
            o_busy     <= 1'b0;
            ack_ph     <= 1'b0;
        end else begin
            bit_cnt    <= bit_cnt_n;
            o_sda_oe   <= sda_oe_n;
            stretch    <= stretch_n;
            o_rx_data  <= rx_data_n;
            o_rx_valid <= rx_valid_n;
            o_tx_req   <= tx_req_n;
            o_start    <= start_n;
            o_stop     <= stop_n;
            o_rw       <= rw_n;
            o_busy     <= busy_n;
            ack_ph     <= ack_ph_n;
        end
    end

    // Shift registers carry data only and need no reset
    always_ff @(posedge clk) begin
        rx_sr <= rx_sr_n;
        tx_sr <= tx_sr_n;
    end

endmodule

// File: tb/tb_i2c_slave.sv
// tb_i2c_slave: directed bus-master bench for i2c_slave at 100 kHz SCL on a 50 MHz clock.
`timescale 1ns/1ps
module tb_i2c_slave;

    localparam int Q = 125;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       m_scl = 1'b1;
    logic       m_sda = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b1;
    logic       scl_line, sda_line;
    logic       o_sda_oe, o_scl_oe, o_rx_valid, o_tx_req, o_start, o_stop, o_rw, o_busy;
    logic [7:0] o_rx_data;

    assign scl_line = m_scl & ~o_scl_oe;
    assign sda_line = m_sda & ~o_sda_oe;

    i2c_slave #(.SLAVE_ADDR(7'h42), .FILTER_LEN(3)) dut (
        .clk(clk), .reset(reset), .i_scl(scl_line), .i_sda(sda_line),
        .o_sda_oe(o_sda_oe), .o_scl_oe(o_scl_oe), .o_rx_data(o_rx_data),
        .o_rx_valid(o_rx_valid), .o_tx_req(o_tx_req), .i_tx_data(tx_data),
        .i_tx_valid(tx_valid), .o_start(o_start), .o_stop(o_stop),
        .o_rw(o_rw), .o_busy(o_busy)
    );

    always #10 clk = ~clk;

    int         n_vec = 0, n_err = 0;
    int         n_rx = 0, n_txreq = 0, n_start = 0, n_stop = 0;
    logic       oe_seen = 1'b0, busy_seen = 1'b0, oe_late = 1'b0, scl_oe_seen = 1'b0;
    logic       clr = 1'b1, late_win = 1'b0;
    logic [7:0] rx_log [0:3];

    always @(negedge clk) begin
        if (o_scl_oe) scl_oe_seen = 1'b1;
        if (clr) begin
            n_rx = 0; n_txreq = 0; n_start = 0; n_stop = 0;
            oe_seen = 1'b0; busy_seen = 1'b0; oe_late = 1'b0;
        end else begin
            if (o_rx_valid) begin
                rx_log[n_rx[1:0]] = o_rx_data;
                n_rx++;
            end
            if (o_tx_req) n_txreq++;
            if (o_start)  n_start++;
            if (o_stop)   n_stop++;
            if (o_sda_oe) oe_seen = 1'b1;
            if (o_busy)   busy_seen = 1'b1;
            if (o_sda_oe && late_win) oe_late = 1'b1;
        end
    end

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clr_mon;
        clr = 1'b1; tick(1); clr = 1'b0;
    endtask

    task automatic i2c_start;
        m_sda = 1'b0; tick(Q); m_scl = 1'b0; tick(Q);
    endtask

    task automatic i2c_rstart;
        m_sda = 1'b1; tick(Q); m_scl = 1'b1; tick(Q); m_sda = 1'b0; tick(Q); m_scl = 1'b0; tick(Q);
    endtask

    task automatic i2c_stop;
        m_sda = 1'b0; tick(Q); m_scl = 1'b1; tick(Q); m_sda = 1'b1; tick(Q);
    endtask

    // One bit cell; an optional 2-clock SCL spike lands mid low phase
    task automatic i2c_bit(input logic b, input bit spike, output logic s);
        m_sda = b;
        tick(60);
        m_scl = spike;
        tick(2);
        m_scl = 1'b0;
        tick(Q - 62);
        m_scl = 1'b1;
        tick(Q);
        s = sda_line;
        tick(Q);
        m_scl = 1'b0;
        tick(Q);
    endtask

    task automatic wr_byte(input logic [7:0] d, input int spike_bit, output logic ack);
        logic unused_bit;
        for (int i = 7; i >= 0; i--) i2c_bit(d[i], (7 - i) == spike_bit, unused_bit);
        i2c_bit(1'b1, 1'b0, ack);
    endtask

    task automatic rd_byte(output logic [7:0] d, input logic nack, input logic [7:0] next_tx);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            i2c_bit(1'b1, 1'b0, s);
            d[i] = s;
        end
        tx_data = next_tx;
        i2c_bit(nack, 1'b0, s);
    endtask

    logic       ack;
    logic [7:0] rd;

    initial begin
        tick(5);
        check_vec("rst_sda_oe_held", 32'(o_sda_oe), 32'd0);
        reset = 1'b0;
        tick(5);
        clr = 1'b0;
        check_vec("rst_sda_oe", 32'(o_sda_oe), 32'd0);
        check_vec("rst_rx_data", 32'(o_rx_data), 32'd0);
        check_vec("rst_rx_valid", 32'(o_rx_valid), 32'd0);
        check_vec("rst_busy", 32'(o_busy), 32'd0);
        check_vec("rst_rw", 32'(o_rw), 32'd0);
        check_vec("rst_start_stop", 32'({o_start, o_stop, o_tx_req}), 32'd0);

        // Write: address 0x42/W, two data bytes
        clr_mon();
        i2c_start();
        wr_byte(8'h84, -1, ack); check_vec("wr_addr_ack", 32'(ack), 32'd0);
        check_vec("wr_rw", 32'(o_rw), 32'd0);
        check_vec("wr_busy", 32'(o_busy), 32'd1);
        wr_byte(8'hA5, -1, ack); check_vec("wr_d0_ack", 32'(ack), 32'd0);
        wr_byte(8'h5A, -1, ack); check_vec("wr_d1_ack", 32'(ack), 32'd0);
        i2c_stop(); tick(20);
        check_vec("wr_rx_cnt", 32'(n_rx), 32'd2);
        check_vec("wr_rx0", 32'(rx_log[0]), 32'hA5);
        check_vec("wr_rx1", 32'(rx_log[1]), 32'h5A);
        check_vec("wr_start_cnt", 32'(n_start), 32'd1);
        check_vec("wr_stop_cnt", 32'(n_stop), 32'd1);
        check_vec("wr_busy_after", 32'(o_busy), 32'd0);
        check_vec("wr_txreq_cnt", 32'(n_txreq), 32'd0);

        // Address miss: 0x43
        clr_mon();
        i2c_start();
        wr_byte(8'h86, -1, ack); check_vec("miss_addr_nack", 32'(ack), 32'd1);
        wr_byte(8'h11, -1, ack); check_vec("miss_data_nack", 32'(ack), 32'd1);
        i2c_stop(); tick(20);
        check_vec("miss_oe_seen", 32'(oe_seen), 32'd0);
        check_vec("miss_rx_cnt", 32'(n_rx), 32'd0);
        check_vec("miss_busy_seen", 32'(busy_seen), 32'd0);
        check_vec("miss_start_cnt", 32'(n_start), 32'd1);
        check_vec("miss_stop_cnt", 32'(n_stop), 32'd1);

        // Read: two bytes, ACK then NACK
        clr_mon();
        tx_data = 8'h3C;
        i2c_start();
        wr_byte(8'h85, -1, ack); check_vec("rd_addr_ack", 32'(ack), 32'd0);
        check_vec("rd_rw", 32'(o_rw), 32'd1);
        check_vec("rd_txreq_first", 32'(n_txreq), 32'd1);
        rd_byte(rd, 1'b0, 8'hC3); check_vec("rd_byte0", 32'(rd), 32'h3C);
        rd_byte(rd, 1'b1, 8'h00); check_vec("rd_byte1", 32'(rd), 32'hC3);
        late_win = 1'b1;
        tick(Q);
        i2c_stop(); tick(20);
        late_win = 1'b0;
        check_vec("rd_oe_after_nack", 32'(oe_late), 32'd0);
        check_vec("rd_txreq_cnt", 32'(n_txreq), 32'd2);
        check_vec("rd_stop_cnt", 32'(n_stop), 32'd1);
        check_vec("rd_busy_after", 32'(o_busy), 32'd0);

        // Repeated START: write 0x07, then read one byte
        clr_mon();
        tx_data = 8'h99;
        i2c_start();
        wr_byte(8'h84, -1, ack); check_vec("rs_addr0_ack", 32'(ack), 32'd0);
        check_vec("rs_rw0", 32'(o_rw), 32'd0);
        wr_byte(8'h07, -1, ack); check_vec("rs_data_ack", 32'(ack), 32'd0);
        check_vec("rs_rx_data", 32'(o_rx_data), 32'h07);
        i2c_rstart();
        check_vec("rs_busy_drop", 32'(o_busy), 32'd0);
        wr_byte(8'h85, -1, ack); check_vec("rs_addr1_ack", 32'(ack), 32'd0);
        check_vec("rs_rw1", 32'(o_rw), 32'd1);
        rd_byte(rd, 1'b1, 8'h00); check_vec("rs_rd_byte", 32'(rd), 32'h99);
        i2c_stop(); tick(20);
        check_vec("rs_start_cnt", 32'(n_start), 32'd2);
        check_vec("rs_stop_cnt", 32'(n_stop), 32'd1);
        check_vec("rs_rx_cnt", 32'(n_rx), 32'd1);

        // Glitches: 1-clk SDA dip in idle, 2-clk SCL spikes mid-byte
        clr_mon();
        m_sda = 1'b0; tick(1); m_sda = 1'b1; tick(50);
        check_vec("gl_no_start", 32'(n_start), 32'd0);
        i2c_start();
        wr_byte(8'h84, 3, ack); check_vec("gl_addr_ack", 32'(ack), 32'd0);
        wr_byte(8'h3E, 5, ack); check_vec("gl_data_ack", 32'(ack), 32'd0);
        i2c_stop(); tick(20);
        check_vec("gl_rx_cnt", 32'(n_rx), 32'd1);
        check_vec("gl_rx0", 32'(rx_log[0]), 32'h3E);
        check_vec("gl_start_cnt", 32'(n_start), 32'd1);

        // Async reset while the slave pulls SDA during the 4th read bit
        clr_mon();
        tx_data = 8'h00;
        i2c_start();
        wr_byte(8'h85, -1, ack); check_vec("ar_addr_ack", 32'(ack), 32'd0);
        for (int i = 0; i < 3; i++) i2c_bit(1'b1, 1'b0, ack);
        m_sda = 1'b1; tick(Q); m_scl = 1'b1; tick(Q / 2);
        check_vec("ar_oe_before", 32'(o_sda_oe), 32'd1);
        #3 reset = 1'b1;
        #1;
        check_vec("ar_oe_async", 32'(o_sda_oe), 32'd0);
        check_vec("ar_busy_async", 32'(o_busy), 32'd0);
        tick(2); reset = 1'b0; tick(2);
        m_scl = 1'b0; tick(Q);
        i2c_stop(); tick(20);
        clr_mon();
        i2c_start();
        wr_byte(8'h84, -1, ack); check_vec("ar_recover_ack", 32'(ack), 32'd0);
        i2c_stop(); tick(20);
        check_vec("ar_start_cnt", 32'(n_start), 32'd1);
        check_vec("scl_oe_never", 32'(scl_oe_seen), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
